// File: rtl/bsg_nand_deser.sv
// Bit-serial A/B pairs in (LSB first), word-wide NAND result out on a valid/yumi port.
// Latency: result valid the edge after the last-bit handshake; one word per width_p cycles.
// Backpressure: non-final bits always accepted; final bit stalls while a result is held unconsumed.
// Optional: define BSG_NAND_DESER_PARITY_EN to add parity_o (even parity of the result word).
module bsg_nand_deser #(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic               a_i,
    input  logic               b_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] o,
    input  logic               yumi_i
`ifdef BSG_NAND_DESER_PARITY_EN
    ,
    output logic               parity_o
`endif
);

    localparam int cnt_w_lp = (width_p > 2) ? $clog2(width_p) : 1;
    localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(width_p - 1);

    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    // Only width_p-1 bits are stored; the final bit is taken straight from the input pins.
    logic [width_p-2:0]  a_sr_q, a_sr_d, b_sr_q, b_sr_d;
    logic [width_p-2:0]  a_shift, b_shift;
    logic [width_p-1:0]  o_q, o_d;
    logic                v_q, v_d;
    logic                is_last, hs, last_hs;
    logic [width_p-1:0]  res_word;

    // Shifting in at the top means the pair taken at count k ends up in bit k once the word completes.
    if (width_p == 2) begin : g_sr_one
        assign a_shift = a_i;
        assign b_shift = b_i;
    end else begin : g_sr_many
        assign a_shift = {a_i, a_sr_q[width_p-2:1]};
        assign b_shift = {b_i, b_sr_q[width_p-2:1]};
    end

    assign is_last  = (cnt_q == last_cnt_lp);
    assign ready_o  = ~is_last | ~v_q | yumi_i;
    assign hs       = v_i & ready_o;
    assign last_hs  = hs & is_last;
    assign res_word = ~({a_i, a_sr_q} & {b_i, b_sr_q});
    assign v_o      = v_q;
    assign o        = o_q;

    // Next-state: count/shift on every handshake, load the result on the last one.
    always_comb begin
        cnt_d  = cnt_q;
        a_sr_d = a_sr_q;
        b_sr_d = b_sr_q;
        o_d    = o_q;
        v_d    = v_q & ~yumi_i;
        if (hs) begin
            a_sr_d = a_shift;
            b_sr_d = b_shift;
            cnt_d  = is_last ? '0 : cnt_q + 1'b1;
        end
        if (last_hs) begin
            o_d = res_word;
            v_d = 1'b1;
        end
    end

    // State registers; reset discards any partial word and any held result.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q  <= '0;
            a_sr_q <= '0;
            b_sr_q <= '0;
            o_q    <= '0;
            v_q    <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            a_sr_q <= a_sr_d;
            b_sr_q <= b_sr_d;
            o_q    <= o_d;
            v_q    <= v_d;
        end
    end

`ifdef BSG_NAND_DESER_PARITY_EN
    logic parity_q;

    // Parity travels with the result word and only changes when a new word loads.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            parity_q <= 1'b0;
        end else if (last_hs) begin
            parity_q <= ^res_word;
        end
    end

    assign parity_o = parity_q;
`endif

endmodule

// File: tb/tb_bsg_nand_deser.sv
// Bench for bsg_nand_deser: directed words plus random traffic against a word-level model.
// Inputs change 1ns after the rising edge; outputs are compared 3ns after the edge.
// Backpressure is exercised by withholding yumi while the next word streams in.
module tb_bsg_nand_deser;

    localparam int W = 16;

    logic         clk_i = 1'b0;
    logic         reset_n_i = 1'b0;
    logic         v_i = 1'b0, a_i = 1'b0, b_i = 1'b0, yumi_i = 1'b0;
    logic         ready_o, v_o;
    logic [W-1:0] o;
`ifdef BSG_NAND_DESER_PARITY_EN
    logic         parity_o;
`endif

    bsg_nand_deser #(.width_p(W)) dut (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .v_i      (v_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .ready_o  (ready_o),
        .v_o      (v_o),
        .o        (o),
        .yumi_i   (yumi_i)
`ifdef BSG_NAND_DESER_PARITY_EN
        ,
        .parity_o (parity_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Word-level model: collected bit pairs of the current word plus the held result.
    logic         ma [W];
    logic         mb [W];
    int           m_k = 0;
    logic         m_v = 1'b0;
    logic [W-1:0] m_o = '0;
    logic         m_p = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_k = 0;
        m_v = 1'b0;
        m_o = '0;
        m_p = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare every output against the model, advance the model.
    task automatic step(input logic v, input logic a, input logic b, input logic y, output logic acc);
        logic         m_rdy;
        logic         yy;
        logic [W-1:0] wa, wb;
        yy     = y & m_v;
        v_i    = v;
        a_i    = a;
        b_i    = b;
        yumi_i = yy;
        #2;
        m_rdy = (m_k != W - 1) || !m_v || yy;
        chk("ready_o", {{(W-1){1'b0}}, ready_o}, {{(W-1){1'b0}}, m_rdy});
        chk("v_o", {{(W-1){1'b0}}, v_o}, {{(W-1){1'b0}}, m_v});
        chk("o", o, m_o);
`ifdef BSG_NAND_DESER_PARITY_EN
        chk("parity_o", {{(W-1){1'b0}}, parity_o}, {{(W-1){1'b0}}, m_p});
`endif
        acc = v & m_rdy;
        @(posedge clk_i);
        #1;
        if (yy) m_v = 1'b0;
        if (acc) begin
            ma[m_k] = a;
            mb[m_k] = b;
            if (m_k == W - 1) begin
                for (int i = 0; i < W; i++) begin
                    wa[i] = ma[i];
                    wb[i] = mb[i];
                end
                m_o = ~(wa & wb);
                m_p = ^m_o;
                m_v = 1'b1;
                m_k = 0;
            end else begin
                m_k = m_k + 1;
            end
        end
        v_i    = 1'b0;
        yumi_i = 1'b0;
    endtask

    // Stream one word LSB first; retries stalled bits within a cycle budget.
    task automatic send_word(input logic [W-1:0] wa, input logic [W-1:0] wb,
                             input logic yumi_last, input logic gaps, output int cycles);
        logic acc;
        int   tries;
        cycles = 0;
        for (int i = 0; i < W; i++) begin
            if (gaps) begin
                int n;
                n = $urandom_range(0, 2);
                for (int g = 0; g < n; g++) begin
                    step(1'b0, 1'($urandom), 1'($urandom), 1'b0, acc);
                    cycles++;
                end
            end
            tries = 0;
            acc   = 1'b0;
            while (!acc && tries < 50) begin
                step(1'b1, wa[i], wb[i], (i == W - 1) && yumi_last, acc);
                cycles++;
                tries++;
            end
            if (!acc) begin
                errors++;
                $display("FAIL send_word timeout: bit %0d never accepted", i);
            end
        end
    endtask

    logic         acc;
    int           cyc;
    int           stalls;
    logic [W-1:0] a2, b2;

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        // Reset values.
        chk("rst_v_o", {{(W-1){1'b0}}, v_o}, '0);
        chk("rst_o", o, '0);
        chk("rst_ready", {{(W-1){1'b0}}, ready_o}, {{(W-1){1'b0}}, 1'b1});
`ifdef BSG_NAND_DESER_PARITY_EN
        chk("rst_parity", {{(W-1){1'b0}}, parity_o}, '0);
`endif
        #2 reset_n_i = 1'b1;

        // Basic word.
        send_word(16'hFFFF, 16'h00FF, 1'b0, 1'b0, cyc);
        chk("basic_o", o, 16'hFF00);
        chk("basic_v", {{(W-1){1'b0}}, v_o}, {{(W-1){1'b0}}, 1'b1});
        step(1'b0, 1'b0, 1'b0, 1'b1, acc);
        chk("basic_v_cleared", {{(W-1){1'b0}}, v_o}, '0);

        // Backpressure: word 1 held, word 2 pre-loads 15 bits then stalls.
        send_word(16'hAAAA, 16'hFFFF, 1'b0, 1'b0, cyc);
        chk("bp_word1", o, 16'h5555);
        a2 = 16'h1357;
        b2 = 16'h9BDF;
        stalls = 0;
        for (int i = 0; i < W - 1; i++) begin
            step(1'b1, a2[i], b2[i], 1'b0, acc);
            if (!acc) stalls++;
        end
        chk("bp_15_accepted", 16'(stalls), 16'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, a2[W-1], b2[W-1], 1'b0, acc);
            if (!acc) stalls++;
        end
        chk("bp_stalls", 16'(stalls), 16'd3);
        chk("bp_o_held", o, 16'h5555);
        step(1'b1, a2[W-1], b2[W-1], 1'b1, acc);
        chk("bp_last_accepted", {{(W-1){1'b0}}, acc}, {{(W-1){1'b0}}, 1'b1});
        chk("bp_word2", o, ~(a2 & b2));
        step(1'b0, 1'b0, 1'b0, 1'b1, acc);

        // Back-to-back words with yumi in every last-bit cycle.
        stalls = 0;
        for (int w = 0; w < 4; w++) begin
            a2 = 16'($urandom);
            b2 = 16'($urandom);
            send_word(a2, b2, 1'b1, 1'b0, cyc);
            stalls += cyc;
            chk("b2b_o", o, ~(a2 & b2));
        end
        chk("b2b_cycles", 16'(stalls), 16'd64);
        chk("b2b_v", {{(W-1){1'b0}}, v_o}, {{(W-1){1'b0}}, 1'b1});

        // Reset mid-word while a result is also held.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 1'b0, acc);
        #2 reset_n_i = 1'b0;
        #1;
        chk("mrst_v_o", {{(W-1){1'b0}}, v_o}, '0);
        chk("mrst_o", o, '0);
        chk("mrst_ready", {{(W-1){1'b0}}, ready_o}, {{(W-1){1'b0}}, 1'b1});
        model_reset();
        @(posedge clk_i);
        #2 reset_n_i = 1'b1;
        send_word(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, cyc);
        chk("mrst_fresh", o, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b1, acc);

        // Idle gaps with toggling data on the idle cycles.
        send_word(16'h1234, 16'h0F0F, 1'b0, 1'b1, cyc);
        chk("gaps_o", o, 16'hFDFB);
        step(1'b0, 1'b0, 1'b0, 1'b1, acc);

`ifdef BSG_NAND_DESER_PARITY_EN
        send_word(16'h0001, 16'h0001, 1'b0, 1'b0, cyc);
        chk("par1_o", o, 16'hFFFE);
        chk("par1_p", {{(W-1){1'b0}}, parity_o}, {{(W-1){1'b0}}, 1'b1});
        step(1'b0, 1'b0, 1'b0, 1'b1, acc);
        send_word(16'h0000, 16'h0000, 1'b0, 1'b0, cyc);
        chk("par0_o", o, 16'hFFFF);
        chk("par0_p", {{(W-1){1'b0}}, parity_o}, '0);
        step(1'b0, 1'b0, 1'b0, 1'b1, acc);
`endif

        // Random traffic: sparse valid, random data, random consumption.
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0, 1'($urandom), 1'($urandom), ($urandom % 3) == 0, acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
